// File: rtl/rx_fifo_arbiter_pkg.sv
// Shared definitions for the RX FIFO arbiter: FSM states, channel IDs, byte helper.
package rx_fifo_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CAPT = 2'd1,
    ST_SEND = 2'd2
  } state_e;

  localparam logic CH_09 = 1'b0;
  localparam logic CH_24 = 1'b1;

  // Index of the first byte sent from a word (bytes go out MSB first).
  localparam logic [1:0] BYTE_IDX_MSB = 2'd3;

  // Select byte idx of a 32-bit word (idx 3 = bits 31:24).
  function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] idx);
    return w[{idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/rx_fifo_arbiter_rr_arb2.sv
// Two-request round-robin grant: on contention the channel not granted last wins.
module rr_arb2
  import rx_fifo_arbiter_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic       i_last_grant,
  output logic       o_any,
  output logic       o_grant
);

  // Pure combinational grant selection.
  always_comb begin
    o_any   = |i_req;
    o_grant = CH_09;
    if (&i_req) begin
      o_grant = ~i_last_grant;
    end else if (i_req[1]) begin
      o_grant = CH_24;
    end
  end

endmodule

// File: rtl/rx_fifo_arbiter.sv
// Round-robin reader of the 0.9 GHz / 2.4 GHz RX FIFOs with per-grant burst
// limit; serialises each 32-bit word MSB first onto a valid/ready byte stream.
module rx_fifo_arbiter
  import rx_fifo_arbiter_pkg::*;
#(
  parameter int unsigned BURST_LEN = 4
) (
  input  logic        i_sys_clk,
  input  logic        i_rst_b,
  input  logic [1:0]  i_ch_en,
  input  logic        i_fifo_09_empty,
  input  logic [31:0] i_fifo_09_data,
  output logic        o_fifo_09_pull,
  input  logic        i_fifo_24_empty,
  input  logic [31:0] i_fifo_24_data,
  output logic        o_fifo_24_pull,
  output logic [7:0]  o_byte,
  output logic        o_byte_valid,
  input  logic        i_byte_ready,
  output logic        o_byte_ch,
  output logic        o_byte_last,
  output logic        o_busy
);

  localparam logic [7:0] BURST_MAX = 8'(BURST_LEN);

  state_e      state_q, state_d;
  logic        grant_q, grant_d;
  logic        last_grant_q, last_grant_d;
  logic [7:0]  burst_cnt_q, burst_cnt_d;
  logic [1:0]  idx_q, idx_d;
  logic [31:0] word_q, word_d;
  // Two-stage run enable: keeps pulls off for two cycles after reset release
  // and holds the Mealy pull outputs low while reset is asserted.
  logic [1:0]  run_q, run_d;

  logic [1:0]  elig;
  logic        arb_any;
  logic        arb_grant;
  logic        pull_en;
  logic        pull_ch;

  assign elig = i_ch_en & ~{i_fifo_24_empty, i_fifo_09_empty};

  rr_arb2 u_rr_arb2 (
    .i_req        (elig),
    .i_last_grant (last_grant_q),
    .o_any        (arb_any),
    .o_grant      (arb_grant)
  );

  // Next-state, burst accounting and pull decision.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    burst_cnt_d  = burst_cnt_q;
    idx_d        = idx_q;
    word_d       = word_q;
    run_d        = {run_q[0], 1'b1};
    pull_en      = 1'b0;
    pull_ch      = grant_q;
    case (state_q)
      ST_IDLE: begin
        if (run_q[1] && arb_any) begin
          grant_d     = arb_grant;
          pull_en     = 1'b1;
          pull_ch     = arb_grant;
          burst_cnt_d = 8'd1;
          state_d     = ST_CAPT;
        end
      end
      ST_CAPT: begin
        word_d  = (grant_q == CH_24) ? i_fifo_24_data : i_fifo_09_data;
        idx_d   = BYTE_IDX_MSB;
        state_d = ST_SEND;
      end
      ST_SEND: begin
        if (i_byte_ready) begin
          if (idx_q != 2'd0) begin
            idx_d = idx_q - 2'd1;
          end else if (run_q[1] && elig[grant_q] && (burst_cnt_q < BURST_MAX)) begin
            pull_en     = 1'b1;
            burst_cnt_d = burst_cnt_q + 8'd1;
            state_d     = ST_CAPT;
          end else begin
            last_grant_d = grant_q;
            burst_cnt_d  = 8'd0;
            state_d      = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register with asynchronous active-low reset; reset drops any word.
  always_ff @(posedge i_sys_clk or negedge i_rst_b) begin
    if (!i_rst_b) begin
      state_q      <= ST_IDLE;
      grant_q      <= CH_09;
      last_grant_q <= CH_24;
      burst_cnt_q  <= 8'd0;
      idx_q        <= 2'd0;
      word_q       <= 32'd0;
      run_q        <= 2'b00;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      burst_cnt_q  <= burst_cnt_d;
      idx_q        <= idx_d;
      word_q       <= word_d;
      run_q        <= run_d;
    end
  end

  assign o_fifo_09_pull = pull_en && (pull_ch == CH_09);
  assign o_fifo_24_pull = pull_en && (pull_ch == CH_24);
  assign o_byte_valid   = (state_q == ST_SEND);
  assign o_byte         = o_byte_valid ? word_byte(word_q, idx_q) : 8'h00;
  assign o_byte_ch      = o_byte_valid & grant_q;
  assign o_byte_last    = o_byte_valid && (idx_q == 2'd0);
  assign o_busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_rx_fifo_arbiter.sv
// Directed bench for rx_fifo_arbiter with queue-based FIFO models.
module tb_rx_fifo_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  ch_en = 2'b00;
  logic        emp09 = 1'b1;
  logic        emp24 = 1'b1;
  logic [31:0] d09 = 32'd0;
  logic [31:0] d24 = 32'd0;
  logic        ready = 1'b1;
  logic        o_fifo_09_pull, o_fifo_24_pull;
  logic [7:0]  o_byte;
  logic        o_byte_valid, o_byte_ch, o_byte_last, o_busy;

  logic [31:0] q09[$];
  logic [31:0] q24[$];
  logic [9:0]  rx[$];
  logic [9:0]  expq[$];
  logic        s09 = 1'b0;
  logic        s24 = 1'b0;
  logic        held_v = 1'b0;
  logic [9:0]  held = 10'd0;
  logic [9:0]  cur;
  int          np09 = 0, np24 = 0, viol = 0, stab_err = 0, nhold = 0;
  int          n_checks = 0, n_errors = 0;

  always #5 clk = ~clk;

  rx_fifo_arbiter #(.BURST_LEN(4)) dut (
    .i_sys_clk       (clk),
    .i_rst_b         (rst_n),
    .i_ch_en         (ch_en),
    .i_fifo_09_empty (emp09),
    .i_fifo_09_data  (d09),
    .o_fifo_09_pull  (o_fifo_09_pull),
    .i_fifo_24_empty (emp24),
    .i_fifo_24_data  (d24),
    .o_fifo_24_pull  (o_fifo_24_pull),
    .o_byte          (o_byte),
    .o_byte_valid    (o_byte_valid),
    .i_byte_ready    (ready),
    .o_byte_ch       (o_byte_ch),
    .o_byte_last     (o_byte_last),
    .o_busy          (o_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end else begin
      $display("ok   %s obs=%h", tag, obs);
    end
  endtask

  // Monitor: sample DUT outputs mid-cycle (negedge).
  always @(negedge clk) begin
    if (rst_n) begin
      if (o_fifo_09_pull) begin s09 = 1'b1; np09++; if (emp09) viol++; end
      if (o_fifo_24_pull) begin s24 = 1'b1; np24++; if (emp24) viol++; end
      if (o_fifo_09_pull && o_fifo_24_pull) viol++;
      cur = {o_byte_ch, o_byte_last, o_byte};
      if (held_v && o_byte_valid && cur !== held) stab_err++;
      if (o_byte_valid && !ready) begin held_v = 1'b1; held = cur; nhold++; end
      else held_v = 1'b0;
      if (o_byte_valid && ready) rx.push_back(cur);
    end
  end

  // FIFO model: a pull seen in cycle t puts the word on the data bus in cycle t+1.
  always @(posedge clk) begin
    #1;
    if (s09 && q09.size() > 0) d09 = q09.pop_front();
    if (s24 && q24.size() > 0) d24 = q24.pop_front();
    s09 = 1'b0;
    s24 = 1'b0;
    emp09 = (q09.size() == 0);
    emp24 = (q24.size() == 0);
  end

  task automatic push09(input logic [31:0] w);
    q09.push_back(w);
    emp09 = 1'b0;
  endtask

  task automatic push24(input logic [31:0] w);
    q24.push_back(w);
    emp24 = 1'b0;
  endtask

  task automatic clear_mon();
    rx.delete(); expq.delete();
    np09 = 0; np24 = 0; viol = 0; stab_err = 0; nhold = 0; held_v = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    ch_en = 2'b00;
    ready = 1'b1;
    q09.delete(); q24.delete();
    emp09 = 1'b1; emp24 = 1'b1; s09 = 1'b0; s24 = 1'b0;
    clear_mon();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic wait_bytes(input int n, input int budget, input string tag);
    int c = 0;
    while (rx.size() < n && c < budget) begin
      @(posedge clk); #1;
      c++;
    end
    chk(tag, rx.size(), n);
  endtask

  // Append the four bytes of word w (MSB first) to the expected stream.
  task automatic exp_word(input logic ch, input logic [31:0] w);
    logic [31:0] t;
    t = w;
    for (int b = 3; b >= 0; b--) expq.push_back({ch, (b == 0), t[8*b +: 8]});
  endtask

  task automatic cmp_stream(input string tag);
    chk({tag, "_len"}, rx.size(), expq.size());
    for (int i = 0; i < expq.size() && i < rx.size(); i++)
      chk($sformatf("%s_b%0d", tag, i), {22'd0, rx[i]}, {22'd0, expq[i]});
  endtask

  logic [31:0] w09[8];
  logic [31:0] w24[8];
  int          pat[4] = '{1, 0, 0, 1};
  int          cnt;
  logic [7:0]  single_exp[4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};

  initial begin
    for (int i = 0; i < 8; i++) begin
      w09[i] = 32'h0911_2200 + i;
      w24[i] = 32'h2455_6600 + i;
    end

    // Reset state
    #3;
    chk("rst_busy", {31'd0, o_busy}, 32'd0);
    chk("rst_valid", {31'd0, o_byte_valid}, 32'd0);
    chk("rst_pulls", {30'd0, o_fifo_09_pull, o_fifo_24_pull}, 32'd0);

    // Single channel timing: pull at t0, bytes t2..t5
    do_reset();
    ch_en = 2'b01;
    push09(32'hA1B2C3D4);
    @(negedge clk);
    chk("single_t0_pull09", {31'd0, o_fifo_09_pull}, 32'd1);
    chk("single_t0_pull24", {31'd0, o_fifo_24_pull}, 32'd0);
    @(negedge clk);
    chk("single_t1_valid", {31'd0, o_byte_valid}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("single_t%0d_byte", k + 2), {21'd0, o_byte_valid, o_byte_ch, o_byte_last, o_byte},
          {21'd0, 1'b1, 1'b0, (k == 3), single_exp[k]});
    end
    @(negedge clk);
    chk("single_idle_busy", {31'd0, o_busy}, 32'd0);
    chk("single_npull", np09, 1);

    // Round-robin with burst limit 4
    do_reset();
    for (int i = 0; i < 8; i++) begin push09(w09[i]); push24(w24[i]); end
    ch_en = 2'b11;
    for (int g = 0; g < 4; g++)
      for (int w = 0; w < 4; w++)
        exp_word(g[0], g[0] ? w24[(g / 2) * 4 + w] : w09[(g / 2) * 4 + w]);
    wait_bytes(64, 400, "rr_count");
    cmp_stream("rr");
    chk("rr_viol", viol, 0);
    chk("rr_np09", np09, 8);
    chk("rr_np24", np24, 8);

    // Backpressure 1,0,0,1
    do_reset();
    ch_en = 2'b01;
    push09(32'h11223344);
    exp_word(1'b0, 32'h11223344);
    cnt = 0;
    while (rx.size() < 4 && cnt < 60) begin
      ready = pat[cnt % 4][0];
      @(posedge clk); #1;
      cnt++;
    end
    ready = 1'b1;
    repeat (3) @(posedge clk); #1;
    cmp_stream("bp");
    chk("bp_stable", stab_err, 0);
    chk("bp_held_seen", {31'd0, nhold != 0}, 32'd1);
    chk("bp_np09", np09, 1);

    // Empty mid-burst: 09 has only 2 words, grant moves to 24
    do_reset();
    push09(w09[0]); push09(w09[1]); push24(w24[0]);
    ch_en = 2'b11;
    exp_word(1'b0, w09[0]); exp_word(1'b0, w09[1]); exp_word(1'b1, w24[0]);
    wait_bytes(12, 200, "emp_count");
    repeat (4) @(posedge clk); #1;
    cmp_stream("emp");
    chk("emp_np09", np09, 2);
    chk("emp_np24", np24, 1);
    chk("emp_viol", viol, 0);

    // Disable 24 during its byte 1
    do_reset();
    push24(w24[0]); push24(w24[1]);
    ch_en = 2'b11;
    wait_bytes(1, 50, "dis_first");
    ch_en = 2'b01;
    push09(w09[3]);
    exp_word(1'b1, w24[0]); exp_word(1'b0, w09[3]);
    wait_bytes(8, 100, "dis_count");
    repeat (6) @(posedge clk); #1;
    cmp_stream("dis");
    chk("dis_np24", np24, 1);
    chk("dis_q24_left", q24.size(), 1);
    chk("dis_np09", np09, 1);

    // Async reset mid-SEND, then no pull for two cycles after release
    do_reset();
    ch_en = 2'b01;
    push09(w09[5]); push09(w09[6]);
    cnt = 0;
    while (!o_byte_valid && cnt < 20) begin @(posedge clk); #1; cnt++; end
    chk("arst_in_send", {31'd0, o_byte_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_outputs", {18'd0, o_byte, o_byte_valid, o_byte_ch, o_byte_last, o_busy,
                         o_fifo_09_pull, o_fifo_24_pull}, 32'd0);
    @(posedge clk); #1;
    clear_mon();
    rst_n = 1'b1;
    @(negedge clk);
    chk("arst_rel_c0_pull", {31'd0, o_fifo_09_pull}, 32'd0);
    @(negedge clk);
    chk("arst_rel_c1_pull", {31'd0, o_fifo_09_pull}, 32'd0);
    exp_word(1'b0, w09[6]);
    wait_bytes(4, 30, "arst_resume");
    cmp_stream("arst");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
